// File: rtl/ps2_pkg.sv
// Shared PS/2 mouse command/response bytes, timer width and bring-up state encoding.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET  = 8'hFF;
    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID     = 8'h00;

    localparam int unsigned TMR_W = 26;

    typedef enum logic [3:0] {
        ST_PWR_WAIT,
        ST_SEND_RST,
        ST_WAIT_ACK1,
        ST_WAIT_BAT,
        ST_WAIT_ID,
        ST_SEND_EN,
        ST_WAIT_ACK2,
        ST_RUN,
        ST_FAIL
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == ST_WAIT_ACK1) || (s == ST_WAIT_BAT) ||
               (s == ST_WAIT_ID)   || (s == ST_WAIT_ACK2);
    endfunction

    function automatic logic [7:0] expected_rsp(input state_t s);
        case (s)
            ST_WAIT_ACK1, ST_WAIT_ACK2: return RSP_ACK;
            ST_WAIT_BAT:                return RSP_BAT_OK;
            default:                    return RSP_ID;
        endcase
    endfunction

    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/ps2_timer.sv
// Countdown timer for the bring-up FSM; expired flags a count of zero outside a load cycle.
module ps2_timer
    import ps2_pkg::*;
#(
    parameter int unsigned RST_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [TMR_W-1:0] limit,
    input  logic             en,
    output logic             expired
);

    logic [TMR_W-1:0] count;

    // The load cycle is itself the first cycle of the window, hence limit-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= TMR_W'(RST_VAL);
        end else if (load) begin
            count <= (limit == '0) ? '0 : limit - TMR_W'(1);
        end else if (en && (count != '0)) begin
            count <= count - TMR_W'(1);
        end
    end

    assign expired = !load && (count == '0);

endmodule

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse bring-up: reset, BAT and ID check, enable streaming, with bounded retries.
module ps2_mouse_init
    import ps2_pkg::*;
#(
    parameter int unsigned PWR_DELAY = 5000000,
    parameter int unsigned T_ACK     = 1000000,
    parameter int unsigned T_BAT     = 50000000,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    output logic       tx_stb,
    output logic [7:0] tx_data,
    input  logic       tx_busy,
    input  logic       tx_err,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       rx_done,
    output logic       run,
    output logic       fail,
    output logic [1:0] retries
);

    state_t           state;
    logic             tmr_load;
    logic             tmr_en;
    logic             tmr_expired;
    logic [TMR_W-1:0] tmr_limit;
    logic             in_wait;
    logic [1:0]       retries_inc;
    logic             hit_max;

    always_comb begin
        in_wait     = is_wait(state);
        tmr_en      = in_wait || (state == ST_PWR_WAIT);
        tmr_limit   = (state == ST_WAIT_BAT) ? TMR_W'(T_BAT) : TMR_W'(T_ACK);
        retries_inc = sat_inc(retries);
        hit_max     = (32'(retries_inc) == MAX_RETRY);
    end

    // Consume is combinational so the held byte is released in the cycle it is judged.
    assign rx_done = !rst && in_wait && rx_rdy;

    ps2_timer #(
        .RST_VAL(PWR_DELAY)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (tmr_load),
        .limit   (tmr_limit),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_PWR_WAIT;
            retries  <= '0;
            tx_stb   <= 1'b0;
            tx_data  <= '0;
            run      <= 1'b0;
            fail     <= 1'b0;
            tmr_load <= 1'b0;
        end else begin
            tx_stb   <= 1'b0;
            tmr_load <= 1'b0;
            if (reinit && (state != ST_PWR_WAIT)) begin
                state   <= ST_SEND_RST;
                retries <= '0;
                run     <= 1'b0;
                fail    <= 1'b0;
            end else begin
                case (state)
                    ST_PWR_WAIT: begin
                        if (tmr_expired) state <= ST_SEND_RST;
                    end
                    ST_SEND_RST, ST_SEND_EN: begin
                        if (tx_err) begin
                            retries <= retries_inc;
                            fail    <= hit_max;
                            state   <= hit_max ? ST_FAIL : ST_SEND_RST;
                        end else if (!tx_busy) begin
                            tx_stb   <= 1'b1;
                            tmr_load <= 1'b1;
                            if (state == ST_SEND_RST) begin
                                tx_data <= CMD_RESET;
                                state   <= ST_WAIT_ACK1;
                            end else begin
                                tx_data <= CMD_ENABLE;
                                state   <= ST_WAIT_ACK2;
                            end
                        end
                    end
                    ST_WAIT_ACK1, ST_WAIT_BAT, ST_WAIT_ID, ST_WAIT_ACK2: begin
                        if (rx_rdy && (rx_data == expected_rsp(state))) begin
                            case (state)
                                ST_WAIT_ACK1: begin
                                    state    <= ST_WAIT_BAT;
                                    tmr_load <= 1'b1;
                                end
                                ST_WAIT_BAT: begin
                                    state    <= ST_WAIT_ID;
                                    tmr_load <= 1'b1;
                                end
                                ST_WAIT_ID: state <= ST_SEND_EN;
                                default: begin
                                    state <= ST_RUN;
                                    run   <= 1'b1;
                                end
                            endcase
                        end else if (rx_rdy && (rx_data == RSP_RESEND) &&
                                     ((state == ST_WAIT_ACK1) || (state == ST_WAIT_ACK2))) begin
                            retries <= retries_inc;
                            fail    <= hit_max;
                            if (hit_max)                    state <= ST_FAIL;
                            else if (state == ST_WAIT_ACK1) state <= ST_SEND_RST;
                            else                            state <= ST_SEND_EN;
                        end else if (rx_rdy || tx_err || tmr_expired) begin
                            retries <= retries_inc;
                            fail    <= hit_max;
                            state   <= hit_max ? ST_FAIL : ST_SEND_RST;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ps2_mouse_init.sv
// Directed bench for ps2_mouse_init, checked every cycle against a reply-sequence model.
`timescale 1ns/1ps
module tb_ps2_mouse_init;

    localparam int unsigned PWR_DELAY = 10;
    localparam int unsigned T_ACK     = 50;
    localparam int unsigned T_BAT     = 100;
    localparam int unsigned MAX_RETRY = 3;
    localparam int RUNNING = 4;
    localparam int FAILED  = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       tx_err = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done;
    logic       run;
    logic       fail;
    logic [1:0] retries;

    ps2_mouse_init #(
        .PWR_DELAY(PWR_DELAY),
        .T_ACK    (T_ACK),
        .T_BAT    (T_BAT),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .reinit  (reinit),
        .tx_stb  (tx_stb),
        .tx_data (tx_data),
        .tx_busy (tx_busy),
        .tx_err  (tx_err),
        .rx_rdy  (rx_rdy),
        .rx_data (rx_data),
        .rx_done (rx_done),
        .run     (run),
        .fail    (fail),
        .retries (retries)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int stb_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Model: m_step indexes the reply sequence FA, AA, 00, FA; 4 = streaming, 5 = given up.
    int m_step = 0;
    int m_retries = 0;
    bit m_listen = 1'b0;
    bit chk_en = 1'b0;

    function automatic logic [7:0] expected_reply(input int step);
        case (step)
            0: return 8'hFA;
            1: return 8'hAA;
            2: return 8'h00;
            default: return 8'hFA;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        m_step = 0;
        m_retries = 0;
        m_listen = 1'b0;
    endtask

    task automatic model_failure();
        if (m_retries < 3) m_retries++;
        m_step = (m_retries == MAX_RETRY) ? FAILED : 0;
        m_listen = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_step < RUNNING && b == expected_reply(m_step)) begin
            m_step++;
            m_listen = (m_step == 1) || (m_step == 2);
        end else if (b == 8'hFE && (m_step == 0 || m_step == 3)) begin
            if (m_retries < 3) m_retries++;
            if (m_retries == MAX_RETRY) m_step = FAILED;
            m_listen = 1'b0;
        end else begin
            model_failure();
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("run", run, 32'(m_step == RUNNING));
            check("fail", fail, 32'(m_step == FAILED));
            check("retries", retries, m_retries);
            check("rx_done", rx_done, 32'(rx_rdy && m_listen));
            if (tx_stb) begin
                stb_count++;
                if (m_step == FAILED) begin
                    n_errors++;
                    $display("FAIL stb_in_fail: tx_stb=1 data %0h, expected no strobe", tx_data);
                end
            end
        end
    end

    task automatic wait_stb(input int budget, input string name, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tx_stb) begin
                at = cyc;
                break;
            end
        end
        n_checks++;
        if (at < 0) begin
            n_errors++;
            $display("FAIL %s: no tx_stb within %0d cycles, expected one", name, budget);
        end else begin
            check({name, "_data"}, tx_data, (m_step == 3) ? 8'hF4 : 8'hFF);
            m_listen = 1'b1;
        end
    endtask

    task automatic reply(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1 rx_data = b; rx_rdy = 1'b1;
        @(negedge clk);
        check("rx_done_same_cycle", rx_done, 1);
        @(posedge clk);
        #1 rx_rdy = 1'b0;
        model_byte(b);
    endtask

    // No reply: the window closes T_ACK cycles after the strobe cycle.
    task automatic expect_timeout();
        repeat (T_ACK + 1) @(posedge clk);
        #1 model_failure();
    endtask

    task automatic pulse_reinit(input logic with_err, output int t);
        @(posedge clk);
        #1 reinit = 1'b1; tx_err = with_err; t = cyc;
        @(posedge clk);
        #1 reinit = 1'b0; tx_err = 1'b0;
        model_clear();
    endtask

    task automatic do_reset(output int rel);
        chk_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1; reinit = 1'b0; tx_err = 1'b0; rx_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; rel = cyc;
        model_clear();
        check("reset_tx_stb", tx_stb, 0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_retries", retries, 0);
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int rel, at, prev, t, n0;

        // Reset state and normal bring-up
        do_reset(rel);
        check("reset_run", run, 0);
        check("reset_fail", fail, 0);
        check("reset_rx_done", rx_done, 0);
        wait_stb(40, "first_cmd", at);
        check("pwr_delay_latency", at - rel, 12);
        reply(8'hFA, 3);
        reply(8'hAA, 5);
        reply(8'h00, 2);
        wait_stb(20, "enable_cmd", at);
        reply(8'hFA, 4);
        @(negedge clk);
        check("run_after_ack", run, 1);
        check("two_cmds", stb_count, 2);
        check("bringup_retries", retries, 0);

        // Streaming bytes are left for downstream
        @(posedge clk);
        #1 rx_data = 8'h08; rx_rdy = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rx_done_in_run", rx_done, 0);
        end
        @(posedge clk);
        #1 rx_rdy = 1'b0;

        // reinit from RUN, then reinit together with tx_err
        pulse_reinit(1'b0, t);
        @(negedge clk);
        check("run_drop", run, 0);
        wait_stb(10, "reinit_cmd", at);
        check("reinit_latency", at - t, 2);
        pulse_reinit(1'b1, t);
        wait_stb(10, "reinit_err_cmd", at);
        check("reinit_beats_err", retries, 0);

        // Three silent timeouts lead to FAIL
        for (int k = 1; k <= 3; k++) begin
            prev = at;
            expect_timeout();
            @(negedge clk);
            check("retries_after_timeout", retries, k);
            if (k < 3) begin
                wait_stb(10, "retry_cmd", at);
                check("retry_interval", at - prev, 52);
            end
        end
        @(posedge clk);
        #1 n0 = stb_count;
        repeat (200) @(negedge clk);
        check("fail_held", fail, 1);
        check("no_run_in_fail", run, 0);
        check("no_stb_in_fail", stb_count - n0, 0);

        // Resend on F4, then ACK
        pulse_reinit(1'b0, t);
        wait_stb(10, "fe_first_cmd", at);
        reply(8'hFA, 2);
        reply(8'hAA, 2);
        reply(8'h00, 2);
        wait_stb(10, "fe_enable_cmd", at);
        reply(8'hFE, 3);
        wait_stb(10, "fe_resend_cmd", at);
        check("fe_resend_data", tx_data, 8'hF4);
        reply(8'hFA, 2);
        @(negedge clk);
        check("fe_run", run, 1);
        check("fe_retries", retries, 1);

        // Bad self-test byte
        pulse_reinit(1'b0, t);
        wait_stb(10, "bat_first_cmd", at);
        reply(8'hFA, 2);
        reply(8'h55, 3);
        wait_stb(10, "bat_retry_cmd", at);
        check("bad_bat_data", tx_data, 8'hFF);
        check("bad_bat_retries", retries, 1);

        // Busy transmitter delays the first command without counting a timeout
        tx_busy = 1'b1;
        do_reset(rel);
        @(posedge clk);
        #1 n0 = stb_count;
        repeat (30) @(posedge clk);
        #1 tx_busy = 1'b0; t = cyc;
        check("no_stb_while_busy", stb_count - n0, 0);
        wait_stb(5, "busy_cmd", at);
        check("busy_release_latency", at - t, 1);
        check("busy_retries", retries, 0);

        // Reset while waiting restarts the power-up delay
        reply(8'hFA, 2);
        do_reset(rel);
        wait_stb(40, "rst_mid_cmd", at);
        check("rst_mid_latency", at - rel, 12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ps2_mouse_init.md
PS2_MOUSE_INIT -- requirements
Module: ps2_mouse_init

Interface
REQ-001 Parameter PWR_DELAY, default 5000000, power-up wait in clk cycles before the first command.
REQ-002 Parameter T_ACK, default 1000000, cycles allowed for an acknowledge byte.
REQ-003 Parameter T_BAT, default 50000000, cycles allowed for the self-test (BAT) byte.
REQ-004 Parameter MAX_RETRY, default 3, failed attempts tolerated before giving up.
REQ-005 One clock; reset is synchronous and active-high: port clk, input, 1, system clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 reinit  input  1  one-cycle pulse that restarts initialisation from SEND_RST.
REQ-008 tx_stb  output  1  one-cycle pulse that starts transmission of tx_data.
REQ-009 tx_data  output  8  command byte to the PS/2 host transmitter.
REQ-010 tx_busy  input  1  transmitter busy.
REQ-011 tx_err  input  1  one-cycle pulse: transmission aborted (no device clock).
REQ-012 rx_rdy  input  1  received byte valid (level, held until consumed).
REQ-013 rx_data  input  8  received byte.
REQ-014 rx_done  output  1  one-cycle consume pulse, asserted only outside RUN.
REQ-015 run  output  1  mouse is streaming; downstream may consume rx bytes.
REQ-016 fail  output  1  initialisation abandoned.
REQ-017 retries  output  2  failed attempts so far.

Function
REQ-018 States: PWR_WAIT, SEND_RST, WAIT_ACK1, WAIT_BAT, WAIT_ID, SEND_EN, WAIT_ACK2, RUN, FAIL.
REQ-019 PWR_WAIT loads PWR_DELAY and counts down; at zero it moves to SEND_RST.
REQ-020 SEND_x states wait for tx_busy=0, then pulse tx_stb for exactly one cycle (SEND_RST: 0xFF, SEND_EN: 0xF4) and move to the next wait state on the following cycle.
REQ-021 On entry to a wait state the timer loads the state's limit: T_ACK for WAIT_ACK1, WAIT_ID and WAIT_ACK2; T_BAT for WAIT_BAT.
REQ-022 In a wait state with rx_rdy=1, rx_done is pulsed in that same cycle and the byte is evaluated in that same cycle.
REQ-023 Expected bytes: WAIT_ACK1 0xFA -> WAIT_BAT; WAIT_BAT 0xAA -> WAIT_ID; WAIT_ID 0x00 -> SEND_EN; WAIT_ACK2 0xFA -> RUN.
REQ-024 Byte 0xFE (resend) in WAIT_ACK1 or WAIT_ACK2 returns to the matching SEND state and increments retries.
REQ-025 Any other unexpected byte, a timer expiry, or tx_err in a SEND or wait state is a failure event.
REQ-026 A failure event increments retries; the FSM enters FAIL if the new count equals MAX_RETRY, otherwise SEND_RST.
REQ-027 retries saturates at 3 and clears only on reset or reinit.
REQ-028 A 0xFE counts toward MAX_RETRY exactly like a failure event.
REQ-029 run=1 only in RUN; fail=1 only in FAIL; both are registered outputs.
REQ-030 In RUN, rx_done=0 and bytes are left for the downstream consumer.
REQ-031 reinit in any state except PWR_WAIT: clear retries, drop run and fail the next cycle, go to SEND_RST; reinit in PWR_WAIT is ignored.
REQ-032 reinit and a failure event in the same cycle: reinit wins.
REQ-033 rx_rdy and timer expiry in the same cycle: the byte wins.
REQ-034 The timer is 26 bits wide and does not count in RUN or FAIL.

Reset
REQ-035 On rst: state PWR_WAIT, timer=PWR_DELAY, retries=0, tx_stb=0, tx_data=0x00, rx_done=0, run=0, fail=0.
REQ-036 rst mid-transmission takes effect in the same cycle; no further tx_stb is issued until PWR_WAIT completes.

Structure
REQ-037 Shared package ps2_pkg holds the command and response byte constants (0xFF, 0xF4, 0xFA, 0xFE, 0xAA, 0x00) and the state encoding.
REQ-038 One sub-module, ps2_timer (load, limit, expired), provides the countdown timer.

Verification
REQ-039 Normal bring-up with small parameters (PWR_DELAY=10, T_ACK=50, T_BAT=100): device replies FA, AA, 00, then FA to F4 -> exactly two tx_stb pulses (0xFF, 0xF4), run=1 one cycle after the last FA, retries=0.
REQ-040 No reply to 0xFF -> after T_ACK cycles retries=1 and 0xFF is resent; after the third timeout fail=1, run=0, no further tx_stb.
REQ-041 Reply FE to 0xF4, then FA -> 0xF4 is sent twice, retries=1, run=1.
REQ-042 Reply 0x55 in WAIT_BAT -> retries=1, next tx_stb carries 0xFF.
REQ-043 reinit pulsed while in RUN -> run=0 next cycle, 0xFF transmitted, retries=0; reinit in the same cycle as tx_err -> retries stays 0.
REQ-044 tx_busy held high for 20 cycles in SEND_RST -> tx_stb is issued in the first cycle after tx_busy falls, and no timeout is counted.
